// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the read-side FIFO arbiter.
package fifo_arb_pkg;

    localparam int DEF_NCH   = 4;
    localparam int DEF_DSIZE = 8;
    localparam int DEF_BURST = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit above last_grant, wrapping.
module rr_pick #(
    parameter int NCH = 4,
    parameter int LW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [LW-1:0]  last_grant,
    output logic           hit,
    output logic [LW-1:0]  index
);

    // NCH is a power of two, so LW-bit addition wraps exactly modulo NCH.
    always_comb begin
        logic [LW-1:0] cand;
        hit   = 1'b0;
        index = last_grant;
        cand  = last_grant;
        for (int k = 1; k <= NCH; k++) begin
            cand = last_grant + LW'(k);
            if (!hit && req[cand]) begin
                hit   = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/rd_fifo_arbiter.sv
// Round-robin burst arbiter draining NCH async-FIFO read ports into one registered stream.
module rd_fifo_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int DSIZE = DEF_DSIZE,
    parameter int BURST = DEF_BURST
) (
    input  logic                     rclk,
    input  logic                     rrst_n,
    input  logic [NCH-1:0]           fifo_rempty,
    input  logic [NCH*DSIZE-1:0]     fifo_rdata,
    output logic [NCH-1:0]           fifo_rinc,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DSIZE-1:0]         m_data,
    output logic [$clog2(NCH)-1:0]   m_chan,
    output logic                     busy
);

    localparam int LW = $clog2(NCH);
    localparam int BW = $clog2(BURST + 1);

    arb_state_t     state;
    logic [LW-1:0]  grant;
    logic [LW-1:0]  last_grant;
    logic [BW-1:0]  burst_cnt;
    logic           pick_hit;
    logic [LW-1:0]  pick_idx;
    logic           out_free;
    logic           grant_empty;
    logic           pop;

    rr_pick #(
        .NCH (NCH),
        .LW  (LW)
    ) u_pick (
        .req        (~fifo_rempty),
        .last_grant (last_grant),
        .hit        (pick_hit),
        .index      (pick_idx)
    );

    // Handshake: a word moves downstream on any edge where m_valid && m_ready;
    // the output register may be reloaded whenever it is empty or being accepted.
    assign out_free    = !m_valid || m_ready;
    assign grant_empty = fifo_rempty[grant];
    assign pop         = rrst_n && (state == XFER) && !grant_empty && out_free;
    assign busy        = (state == XFER);

    always_comb begin
        fifo_rinc = '0;
        if (pop) fifo_rinc[grant] = 1'b1;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LW'(NCH - 1);
            burst_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_hit) begin
                        grant      <= pick_idx;
                        last_grant <= pick_idx;
                        burst_cnt  <= '0;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    // An emptied channel releases the grant without a pop.
                    if (grant_empty) begin
                        state <= IDLE;
                    end else if (pop) begin
                        burst_cnt <= burst_cnt + BW'(1);
                        if (burst_cnt + BW'(1) == BW'(BURST)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= '0;
        end else if (pop) begin
            m_valid <= 1'b1;
            m_data  <= fifo_rdata[grant*DSIZE +: DSIZE];
            m_chan  <= grant;
        end else if (out_free) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rd_fifo_arbiter.sv
// Self-checking bench for rd_fifo_arbiter: per-channel FIFO queues feed the DUT, a behavioural model predicts every cycle.
module tb_rd_fifo_arbiter;

    localparam int NCH   = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;

    logic                   rclk = 1'b0;
    logic                   rrst_n = 1'b0;
    logic [NCH-1:0]         fifo_rempty;
    logic [NCH*DSIZE-1:0]   fifo_rdata;
    logic [NCH-1:0]         fifo_rinc;
    logic                   m_valid;
    logic                   m_ready = 1'b1;
    logic [DSIZE-1:0]       m_data;
    logic [1:0]             m_chan;
    logic                   busy;

    always #5 rclk = ~rclk;

    rd_fifo_arbiter #(
        .NCH   (NCH),
        .DSIZE (DSIZE),
        .BURST (BURST)
    ) dut (
        .rclk        (rclk),
        .rrst_n      (rrst_n),
        .fifo_rempty (fifo_rempty),
        .fifo_rdata  (fifo_rdata),
        .fifo_rinc   (fifo_rinc),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_chan      (m_chan),
        .busy        (busy)
    );

    // FIFO contents, scoreboard and logs
    logic [DSIZE-1:0] chq [NCH][$];
    logic [DSIZE-1:0] exp_q[$];
    logic [DSIZE-1:0] acc_data[$];
    int               acc_chan[$];
    int               acc_cyc[$];
    int               grant_log[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Behavioural model: "serving a channel" plus "what sits in the output slot"
    bit               mdl_busy;
    int               mdl_ch;
    int               mdl_last;
    int               mdl_cnt;
    bit               mdl_valid;
    logic [DSIZE-1:0] mdl_data;
    int               mdl_chan;
    bit               pre_pop;
    bit               pre_free;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mdl_reset();
        mdl_busy  = 1'b0;
        mdl_ch    = 0;
        mdl_last  = NCH - 1;
        mdl_cnt   = 0;
        mdl_valid = 1'b0;
        mdl_data  = '0;
        mdl_chan  = 0;
        exp_q.delete();
    endtask

    function automatic void drive_inputs();
        for (int c = 0; c < NCH; c++) begin
            fifo_rempty[c] = (chq[c].size() == 0);
            fifo_rdata[c*DSIZE +: DSIZE] = (chq[c].size() > 0) ? chq[c][0] : '0;
        end
    endfunction

    // One clock: check outputs at negedge, then advance the model after posedge.
    task automatic cycle();
        logic [NCH-1:0]   exp_rinc;
        logic [DSIZE-1:0] w;
        bit               found;
        drive_inputs();
        @(negedge rclk);
        if (!rrst_n) mdl_reset();
        pre_free = !mdl_valid || m_ready;
        pre_pop  = rrst_n && mdl_busy && (chq[mdl_ch].size() > 0) && pre_free;
        exp_rinc = '0;
        if (pre_pop) exp_rinc[mdl_ch] = 1'b1;
        chk("fifo_rinc", fifo_rinc, exp_rinc);
        chk("busy", busy, mdl_busy);
        chk("m_valid", m_valid, mdl_valid);
        if (mdl_valid || !rrst_n) begin
            chk("m_data", m_data, mdl_data);
            chk("m_chan", m_chan, mdl_chan);
        end
        if (rrst_n && mdl_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: got 0x%0h, expected no word (cycle %0d)", m_data, cyc);
            end else begin
                chk("scoreboard", m_data, exp_q.pop_front());
            end
            acc_data.push_back(m_data);
            acc_chan.push_back(int'(m_chan));
            acc_cyc.push_back(cyc);
        end
        @(posedge rclk);
        #1;
        cyc++;
        if (!rrst_n) begin
            mdl_reset();
        end else begin
            w = '0;
            if (pre_pop) begin
                w = chq[mdl_ch].pop_front();
                exp_q.push_back(w);
            end
            if (!mdl_busy) begin
                found = 1'b0;
                for (int d = 1; d <= NCH; d++) begin
                    int c;
                    c = (mdl_last + d) % NCH;
                    if (!found && chq[c].size() > 0) begin
                        found    = 1'b1;
                        mdl_busy = 1'b1;
                        mdl_ch   = c;
                        mdl_last = c;
                        mdl_cnt  = 0;
                        grant_log.push_back(c);
                    end
                end
            end else if (pre_pop) begin
                mdl_cnt++;
                if (mdl_cnt == BURST) mdl_busy = 1'b0;
            end else if (chq[mdl_ch].size() == 0) begin
                mdl_busy = 1'b0;
            end
            if (pre_pop) begin
                mdl_valid = 1'b1;
                mdl_data  = w;
                mdl_chan  = mdl_ch;
            end else if (pre_free) begin
                mdl_valid = 1'b0;
            end
        end
    endtask

    task automatic clear_logs();
        acc_data.delete();
        acc_chan.delete();
        acc_cyc.delete();
        grant_log.delete();
    endtask

    task automatic reset_all();
        rrst_n  = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < NCH; c++) chq[c].delete();
        cycle();
        cycle();
        rrst_n = 1'b1;
        clear_logs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic chk_chan_seq(input string name, input int e[$]);
        chk({name, "_count"}, acc_chan.size() >= e.size(), 1);
        for (int i = 0; i < e.size() && i < acc_chan.size(); i++)
            chk({name, "_chan"}, acc_chan[i], e[i]);
    endtask

    task automatic chk_data_seq(input string name, input logic [DSIZE-1:0] e[$]);
        chk({name, "_count"}, acc_data.size() >= e.size(), 1);
        for (int i = 0; i < e.size() && i < acc_data.size(); i++)
            chk({name, "_data"}, acc_data[i], e[i]);
    endtask

    initial begin
        int               ec[$];
        logic [DSIZE-1:0] ed[$];
        int               t0;
        int               left;

        mdl_reset();
        for (int c = 0; c < NCH; c++) chq[c].delete();

        // Reset state
        run(2);
        chk("rst_rinc", fifo_rinc, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        rrst_n = 1'b1;
        run(2);

        // Single channel, early release
        reset_all();
        chq[1].push_back(8'hA1);
        chq[1].push_back(8'hA2);
        chq[1].push_back(8'hA3);
        t0 = cyc;
        run(10);
        chk("single_count", acc_data.size(), 3);
        ec = '{1, 1, 1};
        ed = '{8'hA1, 8'hA2, 8'hA3};
        chk_chan_seq("single", ec);
        chk_data_seq("single", ed);
        if (acc_cyc.size() == 3) begin
            chk("single_latency", acc_cyc[0] - t0, 2);
            chk("single_back_to_back", acc_cyc[2] - acc_cyc[0], 2);
        end
        chk("single_idle", busy, 0);

        // Burst limit
        reset_all();
        for (int k = 0; k < 6; k++) chq[0].push_back(8'h10 + 8'(k));
        chq[2].push_back(8'h20);
        chq[2].push_back(8'h21);
        run(30);
        ec = '{0, 0, 0, 0, 2, 2, 0, 0};
        ed = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h14, 8'h15};
        chk_chan_seq("burst", ec);
        chk_data_seq("burst", ed);

        // Fairness with every channel backlogged
        reset_all();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < 8; k++) chq[c].push_back(8'h40 + 8'(c*8 + k));
        run(30);
        ec = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0,0,0,0};
        chk_chan_seq("fair", ec);
        chk("fair_grants", grant_log.size() >= 5, 1);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk("fair_grant_order", grant_log[i], i % NCH);

        // Backpressure mid-burst
        reset_all();
        for (int k = 1; k <= 4; k++) chq[1].push_back(8'h50 + 8'(k));
        run(3);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_data", m_data, 8'h52);
            chk("stall_valid", m_valid, 1);
        end
        m_ready = 1'b1;
        run(10);
        chk("stall_count", acc_data.size(), 4);
        ed = '{8'h51, 8'h52, 8'h53, 8'h54};
        chk_data_seq("stall", ed);

        // Reset mid-burst
        reset_all();
        for (int k = 1; k <= 4; k++) chq[3].push_back(8'h60 + 8'(k));
        run(3);
        chq[0].push_back(8'h71);
        chq[0].push_back(8'h72);
        rrst_n = 1'b0;
        #1;
        chk("midrst_rinc", fifo_rinc, 0);
        chk("midrst_valid", m_valid, 0);
        run(2);
        rrst_n = 1'b1;
        clear_logs();
        run(15);
        ec = '{0, 0, 3, 3};
        ed = '{8'h71, 8'h72, 8'h63, 8'h64};
        chk_chan_seq("midrst", ec);
        chk_data_seq("midrst", ed);

        // Channel runs dry during its burst
        reset_all();
        chq[2].push_back(8'h81);
        for (int k = 1; k <= 3; k++) chq[3].push_back(8'h90 + 8'(k));
        run(15);
        ec = '{2, 3, 3, 3};
        chk_chan_seq("dry", ec);
        chk("dry_grants", grant_log.size(), 2);

        // Randomized traffic with backpressure and occasional resets
        reset_all();
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 3) == 0 && chq[c].size() < 6)
                    chq[c].push_back(8'($urandom));
            m_ready = ($urandom_range(0, 3) != 0);
            rrst_n  = ($urandom_range(0, 399) != 0);
            cycle();
        end
        rrst_n  = 1'b1;
        m_ready = 1'b1;
        run(150);
        left = 0;
        for (int c = 0; c < NCH; c++) left += chq[c].size();
        chk("drain_fifos_empty", left, 0);
        chk("drain_scoreboard_empty", exp_q.size(), 0);
        chk("drain_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
